// File: rtl/tdc_shot_pkg.sv
// Shared definitions for the TDC shot sequencer: FSM state encoding and
// TDC stream field widths/constants.
package tdc_shot_pkg;

    localparam int TOF_W     = 10;
    localparam int INT_W     = 4;
    localparam int HITS_W    = 10;
    localparam int MISS_W    = 8;
    localparam int HIST_BINS = 8;
    localparam int HIST_CW   = 8;

    localparam logic [TOF_W-1:0] TOF_OOR = 10'h3FF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RECV  = 3'd3,
        ST_GAP   = 3'd4,
        ST_PUB   = 3'd5
    } state_e;

endpackage

// File: rtl/tdc_shot_acc.sv
// Frame accumulators for the TDC shot sequencer: nearest in-range depth,
// peak intensity, saturating hit/miss counters and (when the macro
// TDC_SHOT_HIST_EN is defined) an 8-bin depth histogram.
// Registers double as the frame summary outputs; they only change on
// processed beats, miss events or a frame clear, so they hold still while
// the summary is being published.
module tdc_shot_acc
    import tdc_shot_pkg::*;
(
    input  logic              clk5,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              beat_i,
    input  logic              miss_i,
    input  logic [TOF_W-1:0]  odata_i,
    input  logic [INT_W-1:0]  oint_i,
    output logic [TOF_W-1:0]  tof_min_o,
    output logic [INT_W-1:0]  int_max_o,
    output logic [HITS_W-1:0] hits_o,
`ifdef TDC_SHOT_HIST_EN
    output logic [HIST_BINS*HIST_CW-1:0] hist_o,
`endif
    output logic [MISS_W-1:0] miss_o
);

    function automatic logic [HITS_W-1:0] sat_inc_hits(input logic [HITS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [TOF_W-1:0]  tof_min_q, tof_min_d;
    logic [INT_W-1:0]  int_max_q, int_max_d;
    logic [HITS_W-1:0] hits_q, hits_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              hit;

    // An in-range hit is a processed beat whose tof is not the out-of-range code
    assign hit = beat_i && (odata_i != TOF_OOR);

    // Next-state for the scalar accumulators; clear has priority over updates
    always_comb begin
        tof_min_d = tof_min_q;
        int_max_d = int_max_q;
        hits_d    = hits_q;
        miss_d    = miss_q;
        if (clr_i) begin
            tof_min_d = TOF_OOR;
            int_max_d = '0;
            hits_d    = '0;
            miss_d    = '0;
        end else begin
            if (hit) begin
                hits_d = sat_inc_hits(hits_q);
                if (odata_i < tof_min_q) tof_min_d = odata_i;
                if (oint_i > int_max_q)  int_max_d = oint_i;
            end
            if (miss_i) miss_d = sat_inc_miss(miss_q);
        end
    end

    // Accumulator registers; reset values match an empty frame
    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n) begin
            tof_min_q <= TOF_OOR;
            int_max_q <= '0;
            hits_q    <= '0;
            miss_q    <= '0;
        end else begin
            tof_min_q <= tof_min_d;
            int_max_q <= int_max_d;
            hits_q    <= hits_d;
            miss_q    <= miss_d;
        end
    end

    assign tof_min_o = tof_min_q;
    assign int_max_o = int_max_q;
    assign hits_o    = hits_q;
    assign miss_o    = miss_q;

`ifdef TDC_SHOT_HIST_EN
    logic [HIST_BINS-1:0][HIST_CW-1:0] hist_q, hist_d;
    logic [2:0]                        bin;

    assign bin = odata_i[TOF_W-1:TOF_W-3];

    // Histogram bin update, coarse depth taken from the top three tof bits
    always_comb begin
        hist_d = hist_q;
        if (clr_i) begin
            hist_d = '0;
        end else if (hit && (hist_q[bin] != '1)) begin
            hist_d[bin] = hist_q[bin] + 1'b1;
        end
    end

    // Histogram registers
    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n) hist_q <= '0;
        else        hist_q <= hist_d;
    end

    assign hist_o = hist_q;
`endif

endmodule

// File: rtl/tdc_shot_ctrl.sv
// TDC shot sequencer and stream receiver (clk5 domain). Issues start pulses
// and the per-shot range, sinks the TDC beat stream on ph250-strobed cycles
// and publishes a per-frame summary over a valid/ready port.
// Optional histogram output frm_hist is enabled by defining TDC_SHOT_HIST_EN.
module tdc_shot_ctrl
    import tdc_shot_pkg::*;
#(
    parameter int START_W = 4,
    parameter int TIMEOUT = 2048,
    parameter int GAP     = 16
) (
    input  logic              clk5,
    input  logic              rst_n,
    input  logic              ph250,
    input  logic              cfg_en,
    input  logic [14:0]       cfg_range,
    input  logic [7:0]        cfg_shots,
    output logic              tdc_start,
    output logic [14:0]       tdc_range,
    input  logic [TOF_W-1:0]  tdc_odata,
    input  logic [INT_W-1:0]  tdc_oint,
    input  logic [1:0]        tdc_onum,
    input  logic              tdc_olast,
    input  logic              tdc_ovalid,
    output logic              tdc_oready,
    output logic              frm_valid,
    input  logic              frm_ready,
    output logic [TOF_W-1:0]  frm_tof_min,
    output logic [INT_W-1:0]  frm_int_max,
    output logic [HITS_W-1:0] frm_hits,
`ifdef TDC_SHOT_HIST_EN
    output logic [HIST_BINS*HIST_CW-1:0] frm_hist,
`endif
    output logic [MISS_W-1:0] frm_miss
);

    localparam logic [3:0]  START_LAST = 4'(START_W - 1);
    localparam logic [11:0] TO_LAST    = 12'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP - 1);

    state_e      state_q;
    logic        start_q;
    logic [14:0] range_q;
    logic        oready_q;
    logic        fvalid_q;
    logic [3:0]  wcnt_q;
    logic [11:0] timer_q;
    logic [15:0] gcnt_q;
    logic [7:0]  shot_q;
    logic [7:0]  shots_q;

    logic       accept;
    logic       in_rx;
    logic       timeout;
    logic       beat;
    logic       miss;
    logic       clr;
    logic [7:0] shots_eff;

    assign accept    = ph250 && tdc_ovalid && oready_q;
    assign in_rx     = (state_q == ST_WAIT) || (state_q == ST_RECV);
    // A beat in the same cycle always beats the timeout
    assign timeout   = in_rx && !accept && (timer_q == TO_LAST);
    // In WAIT an onum=0 beat is a terminal "no data" marker, not a data beat
    assign beat      = accept && ((state_q == ST_RECV) ||
                                  ((state_q == ST_WAIT) && (tdc_onum != 2'd0)));
    assign miss      = (state_q == ST_WAIT) &&
                       ((accept && (tdc_onum == 2'd0)) || timeout);
    assign clr       = cfg_en && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_PUB) && frm_ready));
    assign shots_eff = (cfg_shots == 8'd0) ? 8'd1 : cfg_shots;

    // Shot/frame sequencer with registered TDC and host-side control outputs
    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            range_q  <= '0;
            oready_q <= 1'b0;
            fvalid_q <= 1'b0;
            wcnt_q   <= '0;
            timer_q  <= '0;
            gcnt_q   <= '0;
            shot_q   <= '0;
            shots_q  <= 8'd1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_en) begin
                        state_q <= ST_START;
                        start_q <= 1'b1;
                        range_q <= cfg_range;
                        wcnt_q  <= '0;
                        shot_q  <= '0;
                        shots_q <= shots_eff;
                    end
                end
                ST_START: begin
                    timer_q <= '0;
                    if (wcnt_q == START_LAST) begin
                        start_q  <= 1'b0;
                        oready_q <= 1'b1;
                        state_q  <= ST_WAIT;
                    end else begin
                        wcnt_q <= wcnt_q + 4'd1;
                    end
                end
                ST_WAIT, ST_RECV: begin
                    if (timer_q != TO_LAST) timer_q <= timer_q + 12'd1;
                    if (accept) begin
                        if (tdc_olast || ((state_q == ST_WAIT) && (tdc_onum == 2'd0))) begin
                            oready_q <= 1'b0;
                            gcnt_q   <= '0;
                            state_q  <= ST_GAP;
                        end else begin
                            state_q <= ST_RECV;
                        end
                    end else if (timeout) begin
                        oready_q <= 1'b0;
                        gcnt_q   <= '0;
                        state_q  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gcnt_q == GAP_LAST) begin
                        shot_q <= shot_q + 8'd1;
                        if ((shot_q + 8'd1) == shots_q) begin
                            fvalid_q <= 1'b1;
                            state_q  <= ST_PUB;
                        end else begin
                            start_q <= 1'b1;
                            range_q <= cfg_range;
                            wcnt_q  <= '0;
                            state_q <= ST_START;
                        end
                    end else begin
                        gcnt_q <= gcnt_q + 16'd1;
                    end
                end
                ST_PUB: begin
                    if (frm_ready) begin
                        fvalid_q <= 1'b0;
                        if (cfg_en) begin
                            start_q <= 1'b1;
                            range_q <= cfg_range;
                            wcnt_q  <= '0;
                            shot_q  <= '0;
                            shots_q <= shots_eff;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tdc_start  = start_q;
    assign tdc_range  = range_q;
    assign tdc_oready = oready_q;
    assign frm_valid  = fvalid_q;

    tdc_shot_acc u_acc (
        .clk5      (clk5),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .beat_i    (beat),
        .miss_i    (miss),
        .odata_i   (tdc_odata),
        .oint_i    (tdc_oint),
        .tof_min_o (frm_tof_min),
        .int_max_o (frm_int_max),
        .hits_o    (frm_hits),
`ifdef TDC_SHOT_HIST_EN
        .hist_o    (frm_hist),
`endif
        .miss_o    (frm_miss)
    );

endmodule

// File: tb/tb_tdc_shot_ctrl.sv
// Directed bench for tdc_shot_ctrl (START_W=4, TIMEOUT=64, GAP=16).
module tb_tdc_shot_ctrl;

    logic        clk5 = 1'b0;
    logic        rst_n;
    logic        ph250;
    logic        cfg_en;
    logic [14:0] cfg_range;
    logic [7:0]  cfg_shots;
    logic        tdc_start;
    logic [14:0] tdc_range;
    logic [9:0]  tdc_odata;
    logic [3:0]  tdc_oint;
    logic [1:0]  tdc_onum;
    logic        tdc_olast;
    logic        tdc_ovalid;
    logic        tdc_oready;
    logic        frm_valid;
    logic        frm_ready;
    logic [9:0]  frm_tof_min;
    logic [3:0]  frm_int_max;
    logic [9:0]  frm_hits;
    logic [7:0]  frm_miss;

    int n_cmp = 0;
    int n_err = 0;

    tdc_shot_ctrl #(.START_W(4), .TIMEOUT(64), .GAP(16)) dut (
        .clk5        (clk5),
        .rst_n       (rst_n),
        .ph250       (ph250),
        .cfg_en      (cfg_en),
        .cfg_range   (cfg_range),
        .cfg_shots   (cfg_shots),
        .tdc_start   (tdc_start),
        .tdc_range   (tdc_range),
        .tdc_odata   (tdc_odata),
        .tdc_oint    (tdc_oint),
        .tdc_onum    (tdc_onum),
        .tdc_olast   (tdc_olast),
        .tdc_ovalid  (tdc_ovalid),
        .tdc_oready  (tdc_oready),
        .frm_valid   (frm_valid),
        .frm_ready   (frm_ready),
        .frm_tof_min (frm_tof_min),
        .frm_int_max (frm_int_max),
        .frm_hits    (frm_hits),
        .frm_miss    (frm_miss)
    );

    always #5 clk5 = ~clk5;

    task automatic tick();
        @(posedge clk5);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_beat(input logic p, input logic v, input logic [9:0] d,
                            input logic [3:0] i, input logic [1:0] n, input logic l);
        ph250      = p;
        tdc_ovalid = v;
        tdc_odata  = d;
        tdc_oint   = i;
        tdc_onum   = n;
        tdc_olast  = l;
    endtask

    task automatic chk_frame(input string tag, input logic [9:0] tof, input logic [3:0] imax,
                             input logic [9:0] hits, input logic [7:0] mis);
        chk({tag, "_valid"}, 32'(frm_valid), 32'd1);
        chk({tag, "_tof"},   32'(frm_tof_min), 32'(tof));
        chk({tag, "_int"},   32'(frm_int_max), 32'(imax));
        chk({tag, "_hits"},  32'(frm_hits), 32'(hits));
        chk({tag, "_miss"},  32'(frm_miss), 32'(mis));
    endtask

    // One single-beat shot, entered with tdc_start just raised; ends with the
    // edge that leaves GAP (next START or PUB).
    task automatic one_shot(input string tag, input logic [9:0] d, input logic [3:0] i,
                            input logic [1:0] n, input logic l);
        repeat (4) tick();
        chk({tag, "_oready_wait"}, 32'(tdc_oready), 32'd1);
        set_beat(1'b1, 1'b1, d, i, n, l);
        tick();
        set_beat(1'b1, 1'b0, 10'h0, 4'h0, 2'd0, 1'b0);
        chk({tag, "_oready_drop"}, 32'(tdc_oready), 32'd0);
        repeat (16) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cfg_en    = 1'b0;
        cfg_range = 15'h0;
        cfg_shots = 8'd1;
        frm_ready = 1'b0;
        set_beat(1'b1, 1'b0, 10'h0, 4'h0, 2'd0, 1'b0);
        repeat (2) tick();

        // Reset state
        chk("rst_start",  32'(tdc_start), 32'd0);
        chk("rst_range",  32'(tdc_range), 32'd0);
        chk("rst_oready", 32'(tdc_oready), 32'd0);
        chk("rst_fvalid", 32'(frm_valid), 32'd0);
        chk("rst_tof",    32'(frm_tof_min), 32'h3FF);
        chk("rst_int",    32'(frm_int_max), 32'd0);
        chk("rst_hits",   32'(frm_hits), 32'd0);
        chk("rst_miss",   32'(frm_miss), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_start", 32'(tdc_start), 32'd0);

        // Frame 1: one shot, two in-range beats, second one behind a ph250=0 cycle
        cfg_shots = 8'd1;
        cfg_range = 15'h1234;
        cfg_en    = 1'b1;
        tick();
        cfg_en = 1'b0;
        chk("f1_start_rise", 32'(tdc_start), 32'd1);
        chk("f1_range", 32'(tdc_range), 32'h1234);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("f1_start_hold", 32'(tdc_start), 32'd1);
        end
        tick();
        chk("f1_start_fall", 32'(tdc_start), 32'd0);
        chk("f1_oready", 32'(tdc_oready), 32'd1);
        set_beat(1'b1, 1'b1, 10'h120, 4'd5, 2'd2, 1'b0);
        tick();
        chk("f1_oready_recv", 32'(tdc_oready), 32'd1);
        set_beat(1'b0, 1'b1, 10'h0A0, 4'd9, 2'd2, 1'b1);
        tick();
        chk("f1_noaccept_ph0", 32'(tdc_oready), 32'd1);
        ph250 = 1'b1;
        tick();
        set_beat(1'b1, 1'b0, 10'h0, 4'h0, 2'd0, 1'b0);
        chk("f1_oready_drop", 32'(tdc_oready), 32'd0);
        repeat (15) tick();
        chk("f1_fvalid_early", 32'(frm_valid), 32'd0);
        tick();
        chk_frame("f1", 10'h0A0, 4'd9, 10'd2, 8'd0);
        frm_ready = 1'b1;
        tick();
        frm_ready = 1'b0;
        chk("f1_fvalid_fall", 32'(frm_valid), 32'd0);
        tick();
        chk("f1_idle_nostart", 32'(tdc_start), 32'd0);

        // Frame 2: cfg_shots=0 (one shot), single onum=0 beat with olast=0
        cfg_shots = 8'd0;
        cfg_en    = 1'b1;
        tick();
        cfg_en = 1'b0;
        chk("f2_start", 32'(tdc_start), 32'd1);
        one_shot("f2", 10'h050, 4'd7, 2'd0, 1'b0);
        chk_frame("f2", 10'h3FF, 4'd0, 10'd0, 8'd1);
        frm_ready = 1'b1;
        tick();
        frm_ready = 1'b0;
        chk("f2_fvalid_fall", 32'(frm_valid), 32'd0);

        // Frame 3: two shots; first times out, second has ph250-gated beat
        cfg_shots = 8'd2;
        cfg_en    = 1'b1;
        tick();
        cfg_en = 1'b0;
        repeat (4) tick();
        chk("f3_oready_up", 32'(tdc_oready), 32'd1);
        repeat (63) tick();
        chk("f3_oready_64", 32'(tdc_oready), 32'd1);
        tick();
        chk("f3_timeout_drop", 32'(tdc_oready), 32'd0);
        repeat (15) tick();
        chk("f3_gap_nostart", 32'(tdc_start), 32'd0);
        tick();
        chk("f3_next_start", 32'(tdc_start), 32'd1);
        repeat (4) tick();
        chk("f3_s2_oready", 32'(tdc_oready), 32'd1);
        set_beat(1'b0, 1'b1, 10'h200, 4'd3, 2'd1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("f3_ph0_hold", 32'(tdc_oready), 32'd1);
        end
        ph250 = 1'b1;
        tick();
        set_beat(1'b1, 1'b0, 10'h0, 4'h0, 2'd0, 1'b0);
        chk("f3_ph1_accept", 32'(tdc_oready), 32'd0);
        repeat (15) tick();
        chk("f3_fvalid_early", 32'(frm_valid), 32'd0);
        tick();
        chk_frame("f3", 10'h200, 4'd3, 10'd1, 8'd1);

        // Host stalls 20 cycles: summary must hold
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("f3_hold_valid", 32'(frm_valid), 32'd1);
            chk("f3_hold_tof", 32'(frm_tof_min), 32'h200);
            chk("f3_hold_hits", 32'(frm_hits), 32'd1);
            chk("f3_hold_miss", 32'(frm_miss), 32'd1);
        end

        // Accept with cfg_en=1 starts frame 4 (three shots) directly
        cfg_shots = 8'd3;
        cfg_en    = 1'b1;
        frm_ready = 1'b1;
        tick();
        cfg_en    = 1'b0;
        frm_ready = 1'b0;
        chk("f4_fvalid_fall", 32'(frm_valid), 32'd0);
        chk("f4_start", 32'(tdc_start), 32'd1);
        one_shot("f4a", 10'h300, 4'd2, 2'd1, 1'b1);
        chk("f4_s2_start", 32'(tdc_start), 32'd1);
        one_shot("f4b", 10'h3FF, 4'd15, 2'd1, 1'b1);
        chk("f4_s3_start", 32'(tdc_start), 32'd1);
        one_shot("f4c", 10'h010, 4'd8, 2'd0, 1'b1);
        chk_frame("f4", 10'h300, 4'd2, 10'd1, 8'd1);
        frm_ready = 1'b1;
        tick();
        frm_ready = 1'b0;
        chk("f4_to_idle", 32'(frm_valid), 32'd0);

        // Frame 5: reset asserted while in RECV
        cfg_shots = 8'd1;
        cfg_range = 15'h0777;
        cfg_en    = 1'b1;
        tick();
        cfg_en = 1'b0;
        repeat (4) tick();
        set_beat(1'b1, 1'b1, 10'h040, 4'd6, 2'd3, 1'b0);
        tick();
        set_beat(1'b1, 1'b0, 10'h0, 4'h0, 2'd0, 1'b0);
        chk("f5_recv_oready", 32'(tdc_oready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("f5_rst_oready", 32'(tdc_oready), 32'd0);
        chk("f5_rst_start", 32'(tdc_start), 32'd0);
        chk("f5_rst_range", 32'(tdc_range), 32'd0);
        chk("f5_rst_fvalid", 32'(frm_valid), 32'd0);
        chk("f5_rst_tof", 32'(frm_tof_min), 32'h3FF);
        chk("f5_rst_int", 32'(frm_int_max), 32'd0);
        chk("f5_rst_hits", 32'(frm_hits), 32'd0);
        chk("f5_rst_miss", 32'(frm_miss), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("f5_idle_oready", 32'(tdc_oready), 32'd0);
        chk("f5_idle_start", 32'(tdc_start), 32'd0);
        cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0;
        chk("f5_restart", 32'(tdc_start), 32'd1);
        chk("f5_restart_range", 32'(tdc_range), 32'h0777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
